pipelined_addsub: RTL and testbench

Parametrised, pipelined add/subtract unit: the successor to the 32-bit combinational adder in the AddSub block. It splits the carry chain across `STAGES` register stages, accepts one operation per cycle under a valid/ready handshake, and returns sum, carry-out and status flags with a pass-through tag. It sits between the ALU operand-select logic and the result writeback mux.

---
 rtl/pipelined_addsub_if.sv | 38 +++
 rtl/pipelined_addsub.sv | 155 +++++++++++++++
 tb/tb_pipelined_addsub.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_addsub_if
// Description : Operand/result handshake bundle for pipelined_addsub.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_addsub_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             sub;
   logic             sat;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             ovf;
   logic             zero;
   logic             neg;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, A, B, Cin, sub, sat, in_tag, out_ready,
      input  in_ready, out_valid, S, Cout, ovf, zero, neg, out_tag
   );

   modport slave (
      input  in_valid, A, B, Cin, sub, sat, in_tag, out_ready,
      output in_ready, out_valid, S, Cout, ovf, zero, neg, out_tag
   );
endinterface
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_addsub
// Description : Carry chain split across STAGES registers, valid/ready flow,
//               optional signed saturation under PIPELINED_ADDSUB_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4,
   parameter int TAG_W  = 4
) (
   input wire clk,
   input wire rst,
   pipelined_addsub_if.slave bus
);
   localparam int CHUNK = WIDTH / STAGES;
   localparam int MSB   = WIDTH - 1;
   localparam int LAST  = STAGES - 1;

   logic [STAGES-1:0] vld_q, vld_d;
   logic [STAGES-1:0] c_q, c_d;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  bx_q  [STAGES];
   logic [WIDTH-1:0]  bx_d  [STAGES];
   logic [WIDTH-1:0]  s_q   [STAGES];
   logic [WIDTH-1:0]  s_d   [STAGES];
   logic [TAG_W-1:0]  tag_q [STAGES];
   logic [TAG_W-1:0]  tag_d [STAGES];
`ifdef PIPELINED_ADDSUB_SAT_EN
   logic [STAGES-1:0] sat_q, sat_d;
`endif
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;
   logic              w_stall;

   assign w_stall      = vld_q[LAST] & ~bus.out_ready;
   assign bus.in_ready = ~w_stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] w_a, w_bx, w_s, w_s_raw;
      logic             w_c, w_v;
      logic [TAG_W-1:0] w_tag;
      logic [CHUNK:0]   w_sum;
`ifdef PIPELINED_ADDSUB_SAT_EN
      logic             w_sat;
`endif

      if (k == 0) begin : g_head
         assign w_a   = bus.A;
         assign w_bx  = bus.sub ? ~bus.B : bus.B;
         assign w_s   = '0;
         assign w_c   = bus.Cin;
         assign w_v   = bus.in_valid;
         assign w_tag = bus.in_tag;
`ifdef PIPELINED_ADDSUB_SAT_EN
         assign w_sat = bus.sat;
`endif
      end else begin : g_body
         assign w_a   = a_q[k-1];
         assign w_bx  = bx_q[k-1];
         assign w_s   = s_q[k-1];
         assign w_c   = c_q[k-1];
         assign w_v   = vld_q[k-1];
         assign w_tag = tag_q[k-1];
`ifdef PIPELINED_ADDSUB_SAT_EN
         assign w_sat = sat_q[k-1];
`endif
      end

      // This stage resolves its own chunk; lower bits ride along already done.
      assign w_sum = {1'b0, w_a[k*CHUNK +: CHUNK]} + {1'b0, w_bx[k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, w_c};

      always_comb begin
         w_s_raw = w_s;
         w_s_raw[k*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
      end

      assign a_d[k]   = w_a;
      assign bx_d[k]  = w_bx;
      assign c_d[k]   = w_sum[CHUNK];
      assign vld_d[k] = w_v;
      assign tag_d[k] = w_tag;
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign sat_d[k] = w_sat;
`endif

      if (k == LAST) begin : g_tail
         logic             w_ovf;
         logic [WIDTH-1:0] w_s_fin;

         assign w_ovf = (w_a[MSB] == w_bx[MSB]) && (w_s_raw[MSB] != w_a[MSB]);
`ifdef PIPELINED_ADDSUB_SAT_EN
         // Clamp toward the sign of A; overflow can only happen when A and Bx agree.
         always_comb begin
            w_s_fin = w_s_raw;
            if (w_sat && w_ovf) begin
               w_s_fin = w_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
         end
`else
         assign w_s_fin = w_s_raw;
`endif
         assign s_d[k]  = w_s_fin;
         assign ovf_d   = w_ovf;
         assign zero_d  = (w_s_fin == '0);
      end else begin : g_pass
         assign s_d[k]  = w_s_raw;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         c_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
`ifdef PIPELINED_ADDSUB_SAT_EN
         sat_q  <= '0;
`endif
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            bx_q[k]  <= '0;
            s_q[k]   <= '0;
            tag_q[k] <= '0;
         end
      end else if (!w_stall) begin
         vld_q  <= vld_d;
         c_q    <= c_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
`ifdef PIPELINED_ADDSUB_SAT_EN
         sat_q  <= sat_d;
`endif
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            bx_q[k]  <= bx_d[k];
            s_q[k]   <= s_d[k];
            tag_q[k] <= tag_d[k];
         end
      end
   end

   assign bus.out_valid = vld_q[LAST];
   assign bus.S         = s_q[LAST];
   assign bus.Cout      = c_q[LAST];
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
   assign bus.neg       = s_q[LAST][MSB];
   assign bus.out_tag   = tag_q[LAST];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_addsub
// Description : Directed self-checking bench for pipelined_addsub at three
//               WIDTH/STAGES points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub;
`ifdef PIPELINED_ADDSUB_SAT_EN
   localparam bit SAT_ON = 1'b1;
`else
   localparam bit SAT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   pipelined_addsub_if #(.WIDTH(32), .TAG_W(4)) bus0 ();
   pipelined_addsub_if #(.WIDTH(16), .TAG_W(4)) bus1 ();
   pipelined_addsub_if #(.WIDTH(64), .TAG_W(4)) bus2 ();

   pipelined_addsub #(.WIDTH(32), .STAGES(4), .TAG_W(4)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   pipelined_addsub #(.WIDTH(16), .STAGES(1), .TAG_W(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   pipelined_addsub #(.WIDTH(64), .STAGES(8), .TAG_W(4)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Default 32-bit / 4-stage instance: result expected on the 4th edge.
   task automatic op0(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sb, input logic st, input logic [3:0] tg,
                      input logic [31:0] es, input logic ec, input logic eo);
      bus0.A = a; bus0.B = b; bus0.Cin = cin; bus0.sub = sb; bus0.sat = st;
      bus0.in_tag = tg; bus0.in_valid = 1'b1;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk({nm, "_early"}, bus0.out_valid, 0);
      @(negedge clk);
      chk({nm, "_valid"}, bus0.out_valid, 1);
      chk({nm, "_S"},     bus0.S, es);
      chk({nm, "_Cout"},  bus0.Cout, ec);
      chk({nm, "_ovf"},   bus0.ovf, eo);
      chk({nm, "_zero"},  bus0.zero, (es == 32'h0));
      chk({nm, "_neg"},   bus0.neg, es[31]);
      chk({nm, "_tag"},   bus0.out_tag, tg);
      @(negedge clk);
   endtask

   task automatic op1(input string nm, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sb, input logic [3:0] tg,
                      input logic [15:0] es, input logic ec);
      bus1.A = a; bus1.B = b; bus1.Cin = cin; bus1.sub = sb; bus1.sat = 1'b0;
      bus1.in_tag = tg; bus1.in_valid = 1'b1;
      #1;
      chk({nm, "_early"}, bus1.out_valid, 0);
      @(negedge clk);
      bus1.in_valid = 1'b0;
      chk({nm, "_valid"}, bus1.out_valid, 1);
      chk({nm, "_S"},     bus1.S, es);
      chk({nm, "_Cout"},  bus1.Cout, ec);
      chk({nm, "_zero"},  bus1.zero, (es == 16'h0));
      chk({nm, "_neg"},   bus1.neg, es[15]);
      chk({nm, "_tag"},   bus1.out_tag, tg);
      @(negedge clk);
   endtask

   task automatic op2(input string nm, input logic [63:0] a, input logic [63:0] b,
                      input logic cin, input logic sb, input logic [3:0] tg,
                      input logic [63:0] es, input logic ec);
      bus2.A = a; bus2.B = b; bus2.Cin = cin; bus2.sub = sb; bus2.sat = 1'b0;
      bus2.in_tag = tg; bus2.in_valid = 1'b1;
      @(negedge clk);
      bus2.in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk({nm, "_early"}, bus2.out_valid, 0);
      @(negedge clk);
      chk({nm, "_valid"}, bus2.out_valid, 1);
      chk({nm, "_S"},     bus2.S, es);
      chk({nm, "_Cout"},  bus2.Cout, ec);
      chk({nm, "_zero"},  bus2.zero, (es == 64'h0));
      chk({nm, "_tag"},   bus2.out_tag, tg);
      @(negedge clk);
   endtask

   logic [31:0] bp_a [8];
   logic [31:0] bp_b [8];
   logic [32:0] bp_e [8];
   int          issued, rcv, nstall, nseen;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus0.in_valid = 0; bus0.A = 0; bus0.B = 0; bus0.Cin = 0; bus0.sub = 0; bus0.sat = 0;
      bus0.in_tag = 0; bus0.out_ready = 1;
      bus1.in_valid = 0; bus1.A = 0; bus1.B = 0; bus1.Cin = 0; bus1.sub = 0; bus1.sat = 0;
      bus1.in_tag = 0; bus1.out_ready = 1;
      bus2.in_valid = 0; bus2.A = 0; bus2.B = 0; bus2.Cin = 0; bus2.sub = 0; bus2.sat = 0;
      bus2.in_tag = 0; bus2.out_ready = 1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", bus0.out_valid, 0);
      chk("rst_S",     bus0.S, 0);
      chk("rst_Cout",  bus0.Cout, 0);
      chk("rst_ovf",   bus0.ovf, 0);
      chk("rst_zero",  bus0.zero, 0);
      chk("rst_neg",   bus0.neg, 0);
      chk("rst_tag",   bus0.out_tag, 0);
      chk("rst_valid16", bus1.out_valid, 0);
      chk("rst_valid64", bus2.out_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", bus0.in_ready, 1);

      op0("add_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 4'd3, 32'hFFFF_FFFF, 1, 0);
      op0("sub_neg",  32'd5, 32'd7, 1, 1, 0, 4'd1, 32'hFFFF_FFFE, 0, 0);
      op0("sub_zero", 32'd7, 32'd7, 1, 1, 0, 4'd2, 32'h0000_0000, 1, 0);
      op0("ovf_pos",  32'h7FFF_FFFF, 32'd1, 0, 0, 1, 4'd5,
          SAT_ON ? 32'h7FFF_FFFF : 32'h8000_0000, 0, 1);
      op0("ovf_neg",  32'h8000_0000, 32'd1, 1, 1, 1, 4'd6,
          SAT_ON ? 32'h8000_0000 : 32'h7FFF_FFFF, 1, 1);
      op0("ovf_nosat", 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 4'd7, 32'h8000_0000, 0, 1);

      // Backpressure: out_ready low for cycles 6..8 of an 8-op stream
      for (int i = 0; i < 8; i++) begin
         bp_a[i] = 32'h7FFF_FF80 + 32'(i) * 32'h40;
         bp_b[i] = 32'h0000_0080 + 32'(i);
         bp_e[i] = {1'b0, bp_a[i]} + {1'b0, bp_b[i]};
      end
      issued = 0; rcv = 0; nstall = 0;
      for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
         bus0.out_ready = !(cyc >= 6 && cyc <= 8);
         if (issued < 8) begin
            bus0.A = bp_a[issued]; bus0.B = bp_b[issued]; bus0.Cin = 0; bus0.sub = 0;
            bus0.sat = 0; bus0.in_tag = 4'(issued); bus0.in_valid = 1'b1;
         end else begin
            bus0.in_valid = 1'b0;
         end
         #1;
         if (bus0.out_valid) begin
            chk("bp_S",   bus0.S, bp_e[rcv][31:0]);
            chk("bp_tag", bus0.out_tag, 4'(rcv));
            if (bus0.out_ready) begin
               chk("bp_Cout", bus0.Cout, bp_e[rcv][32]);
               rcv++;
            end else begin
               nstall++;
               chk("bp_in_ready", bus0.in_ready, 0);
            end
         end
         if (bus0.in_valid && bus0.in_ready) issued++;
         @(negedge clk);
      end
      bus0.in_valid = 1'b0;
      bus0.out_ready = 1'b1;
      chk("bp_count", rcv, 8);
      chk("bp_stalls", nstall, 3);
      @(negedge clk);
      chk("bp_extra", bus0.out_valid, 0);

      // Reset with three operations in flight plus one offered during reset
      for (int i = 0; i < 3; i++) begin
         bus0.A = 32'(i + 1); bus0.B = 32'd10; bus0.Cin = 0; bus0.sub = 0;
         bus0.in_tag = 4'(i + 8); bus0.in_valid = 1'b1;
         @(negedge clk);
      end
      rst = 1'b1;
      bus0.in_tag = 4'd12;
      @(negedge clk);
      rst = 1'b0;
      bus0.in_valid = 1'b0;
      chk("mrst_valid", bus0.out_valid, 0);
      nseen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus0.out_valid) nseen++;
      end
      chk("mrst_flush", nseen, 0);

      op1("w16_add",  16'hFFFF, 16'hFFFF, 1, 0, 4'd3, 16'hFFFF, 1);
      op1("w16_sub",  16'd5, 16'd7, 1, 1, 4'd4, 16'hFFFE, 0);
      op1("w16_zero", 16'd7, 16'd7, 1, 1, 4'd5, 16'h0000, 1);

      op2("w64_add",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 4'd3,
          64'hFFFF_FFFF_FFFF_FFFF, 1);
      op2("w64_sub",  64'd5, 64'd7, 1, 1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      op2("w64_zero", 64'd7, 64'd7, 1, 1, 4'd5, 64'h0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
